laser_pulse_gen_multi: RTL and testbench
========================================

// Module: laser_pulse_gen_multi
// PURPOSE
//  Parametrised N-channel laser pulse generator; successor of the fixed 3-output laser_pulse block.
//  Adds programmable period, pulse width and per-channel delay, plus single, all-channel,
//  round-robin and counted-burst modes. All configuration is shadow-latched at period boundaries.
//  Sits between the AXI laser register bank (EN/MODE/PERIOD/WIDTH/DELAY) and the laser driver pins.
// PARAMETERS
//  NCH    3   number of pulse channels (>=1)
//  CNT_W  24  period counter width (max period 2^CNT_W-1 cycles)
//  W_W    8   pulse width and per-channel delay field width
// PORTS
//  CLK         in   1         system clock, all logic on rising edge
//  RSTn        in   1         synchronous active-low reset
//  EN          in   1         run enable (axi_laser_reg0[0])
//  MODE        in   2         00 CH0 only, 01 all, 10 round-robin, 11 burst
//  PERIOD      in   CNT_W     pulse repetition period in CLK cycles
//  WIDTH       in   W_W       pulse high time in CLK cycles
//  DELAY       in   NCH*W_W   per-channel start offset; channel k = DELAY[k*W_W +: W_W]
//  BURST_LEN   in   16        periods per burst (MODE 11)
//  PULSE       out  NCH       laser trigger outputs, registered
//  PERIOD_TICK out  1         1-cycle strobe at start of every period
//  BUSY        out  1         high in RUN
//  DONE        out  1         1-cycle strobe when a burst completes
// BEHAVIOUR
//  - Reset is synchronous, active-low, and also applies mid-operation. On reset: state IDLE,
//    counter 0, PULSE=0, PERIOD_TICK=0, BUSY=0, DONE=0, RR index 0, burst count 0.
//  - FSM: IDLE -(EN=1)-> RUN; RUN -(EN=0)-> IDLE; RUN -(MODE_s=11 & last burst period ends)-> HOLD;
//    HOLD -(EN=0)-> IDLE. HOLD drives PULSE=0 and BUSY=0.
//  - EN=0 in RUN stops immediately: on the next edge PULSE=0, counter=0 and state is IDLE.
//  - Shadow regs MODE_s/PERIOD_s/WIDTH_s/DELAY_s/BURST_s load on IDLE->RUN and on every period wrap.
//    Mid-period input changes have no effect until the next period.
//  - Counter cnt runs 0..PERIOD_s-1, then wraps. PERIOD_s<2 is clamped to 2. BURST_s=0 is treated as 1.
//  - PERIOD_TICK=1 in the cycle after cnt==0 is registered (aligned with a DELAY=0 pulse rise).
//  - Channel k active when (cnt>=DELAY_k) && (cnt<DELAY_k+WIDTH_s) && sel_k. The compare is done in
//    CNT_W+1 bits, so there is no wrap. PULSE[k] is that term registered: latency 1 cycle.
//  - WIDTH_s=0: no pulse. DELAY_k+WIDTH_s>PERIOD_s: pulse truncated at wrap, never spills into
//    the next period. DELAY_k>=PERIOD_s: channel silent.
//  - First-pulse latency: EN is sampled 1 at edge N, so RUN with cnt=0 after N. With DELAY_k=0,
//    PULSE[k] rises after edge N+1 and stays high exactly WIDTH_s cycles.
//  - sel_k by MODE_s:
//      00: k==0 only.
//      01: all k.
//      10: k==rr, where rr increments mod NCH at each wrap.
//      11: all k, while the burst count is < BURST_s.
//  - Burst: the count increments at each wrap. At the wrap that completes BURST_s periods:
//    DONE=1 for one cycle, then HOLD. EN must fall and rise again to re-arm.
//  - Simultaneous wrap and EN=0: EN wins; go to IDLE with no DONE.
// CONFIGURATION
//  LASER_PULSE_COUNTER_EN defined:
//    adds output PULSE_CNT[31:0], counting PULSE[0] rising edges. Cleared by reset and on
//    IDLE->RUN; saturates at 32'hFFFFFFFF. Used for shot-count telemetry on the AXI bus.
//  Undefined: port and logic are absent, and all other behaviour is identical.
// TESTING (NCH=3, CLK 10 ns)
//  1. RSTn=0 for 2 cycles with EN=1 -> all outputs 0; release -> PULSE[0] rises 2 edges later.
//  2. MODE=01, PERIOD=100, WIDTH=5, DELAY={20,10,0} ->
//     PULSE[0] high at cnt 1..5, PULSE[1] at 11..15, PULSE[2] at 21..25, repeating every 100 cycles.
//  3. MODE=10, PERIOD=50, WIDTH=3 -> exactly one channel pulses per period, order 0,1,2,0.
//  4. MODE=11, BURST_LEN=4, PERIOD=20 -> 4 pulses per channel, DONE high 1 cycle at the 4th wrap,
//     BUSY=0 after; no pulses until EN toggles.
//  5. Change WIDTH 5->9 at cnt=40 of PERIOD=100 -> current pulse stays 5 cycles, next period is 9.
//  6. EN=0 while PULSE[0]=1 (WIDTH=10, 3 cycles in) -> PULSE=0 next edge, BUSY=0, DONE stays 0.
//     Edge cases: WIDTH=0 gives no pulse; DELAY=95, WIDTH=10, PERIOD=100 gives a 5-cycle pulse.

Source files
------------

// File: rtl/laser_pulse_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : laser_pulse_gen_multi
// Description : N-channel laser pulse generator. The period, pulse width,
//               per-channel delay, mode and burst length are shadow-latched
//               when a run starts and again at every period wrap, so input
//               changes made mid-period take effect from the next period.
//               Supported modes: CH0 only, all channels, round-robin and
//               counted burst.
// Ports       : CLK         - system clock, rising edge
//               RSTn        - synchronous active-low reset
//               EN          - run enable
//               MODE        - 00 CH0, 01 all, 10 round-robin, 11 burst
//               PERIOD      - repetition period in CLK cycles (<2 -> 2)
//               WIDTH       - pulse high time in CLK cycles
//               DELAY       - per-channel start offset, ch k at [k*W_W +: W_W]
//               BURST_LEN   - periods per burst (0 -> 1)
//               PULSE       - registered laser triggers
//               PERIOD_TICK - 1-cycle strobe at the start of every period
//               BUSY        - high while running
//               DONE        - 1-cycle strobe when a burst completes
//               PULSE_CNT   - PULSE[0] rising-edge count, saturating
//                             (present only with LASER_PULSE_COUNTER_EN)
// Option      : `define LASER_PULSE_COUNTER_EN to add PULSE_CNT
// Revision    : 1.0 - initial release
// ============================================================================
module laser_pulse_gen_multi #(
  parameter int NCH   = 3,
  parameter int CNT_W = 24,
  parameter int W_W   = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               EN,
  input  logic [1:0]         MODE,
  input  logic [CNT_W-1:0]   PERIOD,
  input  logic [W_W-1:0]     WIDTH,
  input  logic [NCH*W_W-1:0] DELAY,
  input  logic [15:0]        BURST_LEN,
  output logic [NCH-1:0]     PULSE,
  output logic               PERIOD_TICK,
  output logic               BUSY,
  output logic               DONE
`ifdef LASER_PULSE_COUNTER_EN
  ,
  output logic [31:0]        PULSE_CNT
`endif
);

  // Window compare width: one bit wider than the widest operand, so that
  // DELAY_k + WIDTH_s can never wrap.
  localparam int CMP_W = ((CNT_W > W_W) ? CNT_W : W_W) + 1;
  localparam int RR_W  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         mode_s;
  logic [CNT_W-1:0]   period_s;
  logic [W_W-1:0]     width_s;
  logic [NCH*W_W-1:0] delay_s;
  logic [15:0]        burst_s;
  logic [RR_W-1:0]    rr;
  logic [15:0]        bcnt;

  logic               start;
  logic               wrap;
  logic               burst_last;
  logic               run_on;
  logic               stop_burst;
  logic [NCH-1:0]     term;
  logic [NCH-1:0]     pulse_nxt;

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    wrap       = 1'b0;
    burst_last = 1'b0;
    stop_burst = 1'b0;
    run_on     = 1'b0;
    pulse_nxt  = '0;

    wrap       = (state == S_RUN) && (cnt == period_s - CNT_W'(1));
    burst_last = (mode_s == 2'b11) && (({1'b0, bcnt} + 17'd1) >= {1'b0, burst_s});

    case (state)
      S_IDLE: begin
        if (EN) begin
          state_nxt = S_RUN;
          start     = 1'b1;
        end
      end
      S_RUN: begin
        // EN low wins over a simultaneous burst-ending wrap
        if (!EN) begin
          state_nxt = S_IDLE;
        end else if (wrap && burst_last) begin
          state_nxt  = S_HOLD;
          stop_burst = 1'b1;
        end
      end
      S_HOLD: begin
        if (!EN) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    run_on    = (state == S_RUN) && (state_nxt == S_RUN);
    pulse_nxt = run_on ? term : '0;
  end

  // Per-channel window decode on the current count
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [W_W-1:0]   dly;
    logic [CMP_W-1:0] cnt_x;
    logic [CMP_W-1:0] lo_x;
    logic [CMP_W-1:0] hi_x;
    logic             sel;

    assign dly   = delay_s[k*W_W +: W_W];
    assign cnt_x = {{(CMP_W-CNT_W){1'b0}}, cnt};
    assign lo_x  = {{(CMP_W-W_W){1'b0}}, dly};
    assign hi_x  = lo_x + {{(CMP_W-W_W){1'b0}}, width_s};

    always_comb begin
      sel = 1'b0;
      case (mode_s)
        2'b00:   sel = (k == 0);
        2'b01:   sel = 1'b1;
        2'b10:   sel = (rr == RR_W'(k));
        default: sel = (bcnt < burst_s);
      endcase
    end

    assign term[k] = sel && (cnt_x >= lo_x) && (cnt_x < hi_x);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      PULSE       <= '0;
      PERIOD_TICK <= 1'b0;
      DONE        <= 1'b0;
      rr          <= '0;
      bcnt        <= '0;
      mode_s      <= 2'b00;
      period_s    <= CNT_W'(2);
      width_s     <= '0;
      delay_s     <= '0;
      burst_s     <= 16'd1;
    end else begin
      state       <= state_nxt;
      PULSE       <= pulse_nxt;
      PERIOD_TICK <= run_on && (cnt == '0);
      DONE        <= stop_burst;

      // Shadow configuration: on run start and on every period wrap
      if (start || (run_on && wrap)) begin
        mode_s   <= MODE;
        period_s <= (PERIOD < CNT_W'(2)) ? CNT_W'(2) : PERIOD;
        width_s  <= WIDTH;
        delay_s  <= DELAY;
        burst_s  <= (BURST_LEN == 16'd0) ? 16'd1 : BURST_LEN;
      end

      if (start) begin
        cnt  <= '0;
        rr   <= '0;
        bcnt <= '0;
      end else if (run_on) begin
        if (wrap) begin
          cnt <= '0;
          rr  <= (rr == RR_W'(NCH-1)) ? '0 : rr + RR_W'(1);
          if (mode_s == 2'b11) bcnt <= bcnt + 16'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign BUSY = (state == S_RUN);

`ifdef LASER_PULSE_COUNTER_EN
  // Counts at the edge where PULSE[0] rises
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      PULSE_CNT <= '0;
    end else if (start) begin
      PULSE_CNT <= '0;
    end else if (pulse_nxt[0] && !PULSE[0] && (PULSE_CNT != 32'hFFFF_FFFF)) begin
      PULSE_CNT <= PULSE_CNT + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_laser_pulse_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_pulse_gen_multi
// Description : Self-checking bench for laser_pulse_gen_multi (NCH=3).
//               Hand-derived vector table, directed multi-cycle sequences and
//               randomized traffic against a period-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_pulse_gen_multi;

  localparam int NCH   = 3;
  localparam int CNT_W = 24;
  localparam int W_W   = 8;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic               EN;
  logic [1:0]         MODE;
  logic [CNT_W-1:0]   PERIOD;
  logic [W_W-1:0]     WIDTH;
  logic [NCH*W_W-1:0] DELAY;
  logic [15:0]        BURST_LEN;
  logic [NCH-1:0]     PULSE;
  logic               PERIOD_TICK;
  logic               BUSY;
  logic               DONE;

  laser_pulse_gen_multi #(.NCH(NCH), .CNT_W(CNT_W), .W_W(W_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .MODE(MODE), .PERIOD(PERIOD),
    .WIDTH(WIDTH), .DELAY(DELAY), .BURST_LEN(BURST_LEN), .PULSE(PULSE),
    .PERIOD_TICK(PERIOD_TICK), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (period-level, plain integers) --------
  int m_st;   // 0 idle, 1 running, 2 burst hold
  int m_pos;  // cycles elapsed in the current period
  int m_rr, m_bc;
  int c_mode, c_per, c_wid, c_burst;
  int c_del[NCH];
  logic [NCH-1:0] e_pulse;
  logic e_tick, e_busy, e_done;

  function automatic void model_load();
    c_mode  = int'(MODE);
    c_per   = (int'(PERIOD) < 2) ? 2 : int'(PERIOD);
    c_wid   = int'(WIDTH);
    c_burst = (BURST_LEN == 0) ? 1 : int'(BURST_LEN);
    for (int k = 0; k < NCH; k++) c_del[k] = int'(DELAY[k*W_W +: W_W]);
  endfunction

  // Advances the model by one clock edge using the inputs seen at that edge.
  function automatic void model_edge();
    logic [NCH-1:0] p;
    bit sel;
    p = '0; e_tick = 0; e_done = 0;
    if (!RSTn) begin
      m_st = 0; m_pos = 0; m_rr = 0; m_bc = 0;
    end else if (m_st == 0) begin
      if (EN) begin
        m_st = 1; m_pos = 0; m_rr = 0; m_bc = 0; model_load();
      end
    end else if (m_st == 1) begin
      if (!EN) begin
        m_st = 0; m_pos = 0;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          case (c_mode)
            0: sel = (k == 0);
            2: sel = (k == m_rr);
            3: sel = (m_bc < c_burst);
            default: sel = 1;
          endcase
          if (sel && m_pos >= c_del[k] && m_pos < c_del[k] + c_wid) p[k] = 1'b1;
        end
        e_tick = (m_pos == 0);
        if (m_pos == c_per - 1) begin
          m_pos = 0;
          if (c_mode == 3 && m_bc + 1 >= c_burst) begin
            m_st = 2; e_done = 1; p = '0;
          end else begin
            m_rr = (m_rr + 1) % NCH;
            if (c_mode == 3) m_bc++;
            model_load();
          end
        end else begin
          m_pos++;
        end
      end
    end else begin
      if (!EN) m_st = 0;
    end
    e_pulse = p;
    e_busy  = (m_st == 1);
  endfunction

  // ---------------- per-cycle stats --------------------------------------
  logic [NCH-1:0] prev_p;
  int rises[NCH];
  int high_cnt[NCH];
  int done_cnt, cur_len;
  int lens[$];
  int order[$];

  task automatic clear_stats();
    prev_p = PULSE; done_cnt = 0; cur_len = 0;
    lens.delete(); order.delete();
    for (int k = 0; k < NCH; k++) begin rises[k] = 0; high_cnt[k] = 0; end
  endtask

  task automatic update_stats();
    for (int k = 0; k < NCH; k++) begin
      if (PULSE[k] && !prev_p[k]) begin rises[k]++; order.push_back(k); end
      if (PULSE[k]) high_cnt[k]++;
    end
    if (PULSE[0]) cur_len++;
    else if (prev_p[0]) begin lens.push_back(cur_len); cur_len = 0; end
    if (DONE) done_cnt++;
    prev_p = PULSE;
  endtask

  // One clock: sample 1 ns after the edge, compare with the model
  task automatic step();
    @(posedge CLK); #1;
    model_edge();
    chk("pulse", 32'(PULSE), 32'(e_pulse));
    chk("tick",  32'(PERIOD_TICK), 32'(e_tick));
    chk("busy",  32'(BUSY), 32'(e_busy));
    chk("done",  32'(DONE), 32'(e_done));
    update_stats();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int m, input int p, input int w,
                         input int d2, input int d1, input int d0, input int b);
    MODE = 2'(m); PERIOD = CNT_W'(p); WIDTH = W_W'(w);
    DELAY = {W_W'(d2), W_W'(d1), W_W'(d0)}; BURST_LEN = 16'(b);
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    logic       rstn;
    logic       en;
    logic [2:0] pulse;
    logic       tick;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tv[10];

  function automatic vec_t mkv(input logic r, input logic e, input logic [2:0] p,
                               input logic t, input logic bz, input logic d);
    vec_t v;
    v.rstn = r; v.en = e; v.pulse = p; v.tick = t; v.busy = bz; v.done = d;
    return v;
  endfunction

  int exp_ord[4] = '{0, 1, 2, 0};

  initial begin
    RSTn = 1'b0; EN = 1'b1;
    // MODE 01, PERIOD 4, WIDTH 2, DELAY ch2=2 ch1=1 ch0=0
    set_cfg(1, 4, 2, 2, 1, 0, 1);
    m_st = 0; m_pos = 0; m_rr = 0; m_bc = 0; model_load();
    clear_stats();

    tv[0] = mkv(0, 1, 3'b000, 0, 0, 0);
    tv[1] = mkv(0, 1, 3'b000, 0, 0, 0);
    tv[2] = mkv(1, 1, 3'b000, 0, 1, 0);  // edge N: RUN, cnt 0
    tv[3] = mkv(1, 1, 3'b001, 1, 1, 0);  // ch0 rises 2 edges after release
    tv[4] = mkv(1, 1, 3'b011, 0, 1, 0);
    tv[5] = mkv(1, 1, 3'b110, 0, 1, 0);
    tv[6] = mkv(1, 1, 3'b100, 0, 1, 0);
    tv[7] = mkv(1, 1, 3'b001, 1, 1, 0);  // next period
    tv[8] = mkv(1, 0, 3'b000, 0, 0, 0);  // EN low stops at once
    tv[9] = mkv(1, 0, 3'b000, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      RSTn = tv[i].rstn; EN = tv[i].en;
      @(posedge CLK); #1;
      model_edge();
      chk($sformatf("vec%0d_pulse", i), 32'(PULSE), 32'(tv[i].pulse));
      chk($sformatf("vec%0d_tick", i),  32'(PERIOD_TICK), 32'(tv[i].tick));
      chk($sformatf("vec%0d_busy", i),  32'(BUSY), 32'(tv[i].busy));
      chk($sformatf("vec%0d_done", i),  32'(DONE), 32'(tv[i].done));
    end

    // All channels, PERIOD 100, WIDTH 5, DELAY {20,10,0}
    set_cfg(1, 100, 5, 20, 10, 0, 1);
    EN = 1'b1; clear_stats(); run(250);
    for (int k = 0; k < NCH; k++) chk($sformatf("all_high_ch%0d", k), 32'(high_cnt[k]), 32'd15);

    // Round-robin order 0,1,2,0
    EN = 1'b0; run(2);
    set_cfg(2, 50, 3, 0, 0, 0, 1);
    EN = 1'b1; clear_stats(); run(200);
    chk("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_ord[i]));

    // Burst of 4
    EN = 1'b0; run(2);
    set_cfg(3, 20, 2, 0, 0, 0, 4);
    EN = 1'b1; clear_stats(); run(120);
    for (int k = 0; k < NCH; k++) chk($sformatf("burst_rises_ch%0d", k), 32'(rises[k]), 32'd4);
    chk("burst_done_cnt", 32'(done_cnt), 32'd1);
    chk("burst_busy_after", 32'(BUSY), 32'd0);
    EN = 1'b0; run(1);
    EN = 1'b1; run(5);

    // Width change mid-period applies next period
    EN = 1'b0; run(2);
    set_cfg(0, 100, 5, 0, 0, 0, 1);
    EN = 1'b1; clear_stats(); run(41);
    WIDTH = W_W'(9); run(160);
    chk("wchg_runs", 32'(lens.size()), 32'd2);
    if (lens.size() == 2) begin
      chk("wchg_first", 32'(lens[0]), 32'd5);
      chk("wchg_second", 32'(lens[1]), 32'd9);
    end

    // EN drop 3 cycles into a WIDTH=10 pulse
    EN = 1'b0; run(2);
    set_cfg(0, 100, 10, 0, 0, 0, 1);
    EN = 1'b1; run(4);
    chk("endrop_pre", 32'(PULSE[0]), 32'd1);
    EN = 1'b0; run(1);
    chk("endrop_pulse", 32'(PULSE), 32'd0);
    chk("endrop_busy", 32'(BUSY), 32'd0);
    chk("endrop_done", 32'(DONE), 32'd0);
    run(2);

    // WIDTH 0: silent
    set_cfg(1, 10, 0, 5, 3, 0, 1);
    EN = 1'b1; clear_stats(); run(30);
    chk("w0_high", 32'(high_cnt[0] + high_cnt[1] + high_cnt[2]), 32'd0);

    // Truncation at wrap: DELAY 95, WIDTH 10, PERIOD 100
    EN = 1'b0; run(2);
    set_cfg(0, 100, 10, 0, 0, 95, 1);
    EN = 1'b1; clear_stats(); run(210);
    chk("trunc_runs", 32'(lens.size()), 32'd2);
    if (lens.size() >= 1) chk("trunc_len", 32'(lens[0]), 32'd5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      RSTn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) EN = ~EN;
      if ($urandom_range(0, 14) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 24), $urandom_range(0, 12),
                $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25),
                $urandom_range(0, 5));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
